// File: rtl/ag32_axi_pkg.sv
// Shared AXI definitions for the ag32 memory responder: response codes, the
// word transfer size, FSM state types and the request legality rule.
package ag32_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [2:0] SIZE_WORD   = 3'b010;

  typedef enum logic {W_COLLECT, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  // A single aligned word inside the window [base, base+span).
  function automatic logic req_legal(input logic [31:0] addr,
                                     input logic [7:0]  len,
                                     input logic [2:0]  size,
                                     input logic [31:0] base,
                                     input logic [32:0] span);
    logic [32:0] off;
    off = {1'b0, addr} - {1'b0, base};
    return (len == 8'd0) && (size == SIZE_WORD) && (addr[1:0] == 2'b00) &&
           (addr >= base) && (off < span);
  endfunction

endpackage

// File: rtl/ram_be_dp.sv
// Word-wide RAM with one byte-enabled write port and one registered read port;
// a read and a write to the same word on one edge returns the old contents.
module ram_be_dp #(
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [3:0]       wstrb,
  input  logic             re,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; a reset loop would force registers.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi_mem_responder.sv
// Single-beat AXI4 memory slave: independent write (AW+W -> B) and read
// (AR -> R) state machines in front of a byte-enabled dual-port RAM.
module axi_mem_responder
  import ag32_axi_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        s_awvalid,
  output logic        s_awready,
  input  logic [31:0] s_awaddr,
  input  logic [7:0]  s_awlen,
  input  logic [2:0]  s_awsize,
  input  logic [1:0]  s_awburst,
  input  logic        s_wvalid,
  output logic        s_wready,
  input  logic [31:0] s_wdata,
  input  logic [3:0]  s_wstrb,
  input  logic        s_wlast,
  output logic        s_bvalid,
  input  logic        s_bready,
  output logic [1:0]  s_bresp,
  input  logic        s_arvalid,
  output logic        s_arready,
  input  logic [31:0] s_araddr,
  input  logic [7:0]  s_arlen,
  input  logic [2:0]  s_arsize,
  input  logic [1:0]  s_arburst,
  output logic        s_rvalid,
  input  logic        s_rready,
  output logic [31:0] s_rdata,
  output logic [1:0]  s_rresp,
  output logic        s_rlast
);

  localparam int          IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) << 2;

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
    return IDX_W'((addr - ADDR_BASE) >> 2);
  endfunction

  w_state_t         w_state;
  r_state_t         r_state;
  logic             aw_held, w_held, aw_ok_q, wlast_q;
  logic [IDX_W-1:0] aw_idx_q;
  logic [31:0]      wdata_q;
  logic [3:0]       wstrb_q;
  logic             aw_fire, w_fire, ar_fire, ar_ok, commit, wr_ok, ram_we;
  logic             cur_aw_ok, cur_wlast;
  logic [IDX_W-1:0] cur_idx;
  logic [31:0]      cur_wdata, ram_rdata;
  logic [3:0]       cur_wstrb;
  logic             rd_ok_q;
  logic             unused_burst;

  assign unused_burst = ^{s_awburst, s_arburst};

  // Readies are gated by resetn so they drop as soon as reset is applied.
  assign s_awready = resetn && (w_state == W_COLLECT) && !aw_held;
  assign s_wready  = resetn && (w_state == W_COLLECT) && !w_held;
  assign s_bvalid  = (w_state == W_RESP);
  assign s_arready = resetn && (r_state == R_IDLE);
  assign s_rvalid  = (r_state == R_DATA);
  assign s_rlast   = 1'b1;
  assign s_rdata   = rd_ok_q ? ram_rdata : 32'd0;

  assign aw_fire = s_awvalid && s_awready;
  assign w_fire  = s_wvalid && s_wready;
  assign ar_fire = s_arvalid && s_arready;
  assign ar_ok   = req_legal(s_araddr, s_arlen, s_arsize, ADDR_BASE, SPAN);

  // A channel arriving this cycle is used directly so the commit costs no extra cycle.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    cur_aw_ok = req_legal(s_awaddr, s_awlen, s_awsize, ADDR_BASE, SPAN);
    cur_idx   = word_idx(s_awaddr);
    cur_wdata = s_wdata;
    cur_wstrb = s_wstrb;
    cur_wlast = s_wlast;
    if (aw_held) begin
      cur_aw_ok = aw_ok_q;
      cur_idx   = aw_idx_q;
    end
    if (w_held) begin
      cur_wdata = wdata_q;
      cur_wstrb = wstrb_q;
      cur_wlast = wlast_q;
    end
    commit = (aw_held || aw_fire) && (w_held || w_fire);
    wr_ok  = cur_aw_ok && cur_wlast;
    ram_we = commit && wr_ok;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      w_state <= W_COLLECT;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      s_bresp <= RESP_OKAY;
    end else begin
      case (w_state)
        W_COLLECT: begin
          if (commit) begin
            w_state <= W_RESP;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            s_bresp <= wr_ok ? RESP_OKAY : RESP_SLVERR;
          end else begin
            if (aw_fire) aw_held <= 1'b1;
            if (w_fire)  w_held  <= 1'b1;
          end
        end
        W_RESP:  if (s_bready) w_state <= W_COLLECT;
        default: w_state <= W_COLLECT;
      endcase
    end
  end

  // Captured payload is only consulted while its held flag is set.
  always_ff @(posedge clk) begin
    if (aw_fire) begin
      aw_ok_q  <= cur_aw_ok;
      aw_idx_q <= cur_idx;
    end
    if (w_fire) begin
      wdata_q <= s_wdata;
      wstrb_q <= s_wstrb;
      wlast_q <= s_wlast;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= R_IDLE;
      rd_ok_q <= 1'b0;
      s_rresp <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_fire) begin
            r_state <= R_DATA;
            rd_ok_q <= ar_ok;
            s_rresp <= ar_ok ? RESP_OKAY : RESP_SLVERR;
          end
        end
        R_DATA:  if (s_rready) r_state <= R_IDLE;
        default: r_state <= R_IDLE;
      endcase
    end
  end

  ram_be_dp #(.DEPTH(DEPTH_WORDS), .IDX_W(IDX_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (cur_idx),
    .wdata (cur_wdata),
    .wstrb (cur_wstrb),
    .re    (ar_fire && ar_ok),
    .raddr (word_idx(s_araddr)),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_axi_mem_responder.sv
// Self-checking bench for axi_mem_responder: directed scenarios plus random
// single-beat traffic compared against a word-array reference model.
module tb_axi_mem_responder;
  import ag32_axi_pkg::*;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 16;
  localparam int          TMO   = 50;

  logic        clk = 1'b0;
  logic        resetn;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_wlast;
  logic        s_bvalid, s_bready, s_arvalid, s_arready;
  logic        s_rvalid, s_rready, s_rlast;
  logic [31:0] s_awaddr, s_araddr, s_wdata, s_rdata;
  logic [7:0]  s_awlen, s_arlen;
  logic [2:0]  s_awsize, s_arsize;
  logic [1:0]  s_awburst, s_arburst, s_bresp, s_rresp;
  logic [3:0]  s_wstrb;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model [DEPTH];

  axi_mem_responder #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .resetn(resetn),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rlast(s_rlast)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    n_checks++;
    n_fail++;
    $error("FAIL %s: observed no handshake within %0d cycles, expected handshake", tag, TMO);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit ref_legal(input logic [31:0] addr, input logic [7:0] len,
                                   input logic [2:0] size);
    longint a;
    a = longint'(addr);
    return (len == 8'd0) && (size == 3'd2) && (a % 4 == 0) &&
           (a >= longint'(BASE)) && (a < longint'(BASE) + 4 * DEPTH);
  endfunction

  function automatic int ref_idx(input logic [31:0] addr);
    longint a;
    a = longint'(addr) - longint'(BASE);
    return int'(a / 4);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
    return r;
  endfunction

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [31:0] data, input logic [3:0] strb, input logic last,
                          input string tag);
    bit aw_done, w_done, aw_now, w_now, ok;
    int t;
    ok = ref_legal(addr, len, size) && last;
    aw_done = 0; w_done = 0; t = 0;
    s_awvalid = 1; s_awaddr = addr; s_awlen = len; s_awsize = size; s_awburst = 2'b01;
    s_wvalid = 1; s_wdata = data; s_wstrb = strb; s_wlast = last;
    while (!(aw_done && w_done) && t < TMO) begin
      aw_now = s_awvalid && s_awready;
      w_now  = s_wvalid && s_wready;
      step();
      if (aw_now) begin aw_done = 1; s_awvalid = 0; end
      if (w_now)  begin w_done = 1;  s_wvalid = 0;  end
      t++;
    end
    s_awvalid = 0; s_wvalid = 0;
    if (!(aw_done && w_done)) begin timeout_fail({tag, " aw/w"}); return; end
    t = 0;
    while (!s_bvalid && t < TMO) begin step(); t++; end
    if (!s_bvalid) begin timeout_fail({tag, " b"}); return; end
    check({tag, " bresp"}, 32'(s_bresp), ok ? 32'(RESP_OKAY) : 32'(RESP_SLVERR));
    s_bready = 1;
    step();
    s_bready = 0;
    if (ok) model[ref_idx(addr)] = merge(model[ref_idx(addr)], data, strb);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input string tag, output logic [31:0] rd);
    bit ok, done;
    int t;
    ok = ref_legal(addr, len, size);
    done = 0; t = 0; rd = 32'hx;
    s_arvalid = 1; s_araddr = addr; s_arlen = len; s_arsize = size; s_arburst = 2'b01;
    while (!done && t < TMO) begin
      done = s_arready;
      step();
      t++;
    end
    s_arvalid = 0;
    if (!done) begin timeout_fail({tag, " ar"}); return; end
    t = 0;
    while (!s_rvalid && t < TMO) begin step(); t++; end
    if (!s_rvalid) begin timeout_fail({tag, " r"}); return; end
    rd = s_rdata;
    check({tag, " rdata"}, s_rdata, ok ? model[ref_idx(addr)] : 32'd0);
    check({tag, " rresp"}, 32'(s_rresp), ok ? 32'(RESP_OKAY) : 32'(RESP_SLVERR));
    check({tag, " rlast"}, 32'(s_rlast), 32'd1);
    s_rready = 1;
    step();
    s_rready = 0;
  endtask

  initial begin
    logic [31:0] rd, old, hold_rdata;
    logic [31:0] a;
    logic [7:0]  len;
    logic [2:0]  sz;
    int          kind;

    resetn = 0;
    s_awvalid = 0; s_awaddr = '0; s_awlen = '0; s_awsize = SIZE_WORD; s_awburst = 2'b01;
    s_wvalid = 0; s_wdata = '0; s_wstrb = '0; s_wlast = 1;
    s_bready = 0;
    s_arvalid = 0; s_araddr = '0; s_arlen = '0; s_arsize = SIZE_WORD; s_arburst = 2'b01;
    s_rready = 0;

    // Reset values
    repeat (3) step();
    check("rst awready", 32'(s_awready), 32'd0);
    check("rst wready",  32'(s_wready),  32'd0);
    check("rst arready", 32'(s_arready), 32'd0);
    check("rst bvalid",  32'(s_bvalid),  32'd0);
    check("rst rvalid",  32'(s_rvalid),  32'd0);
    check("rst bresp",   32'(s_bresp),   32'd0);
    check("rst rresp",   32'(s_rresp),   32'd0);
    check("rst rdata",   s_rdata,        32'd0);
    check("rst rlast",   32'(s_rlast),   32'd1);
    resetn = 1;
    #1;
    check("post-rst awready", 32'(s_awready), 32'd1);
    check("post-rst wready",  32'(s_wready),  32'd1);
    check("post-rst arready", 32'(s_arready), 32'd1);

    // Fill every word so the model is fully known
    for (int i = 0; i < DEPTH; i++)
      do_write(BASE + 32'(4 * i), 8'd0, SIZE_WORD, $urandom, 4'hF, 1'b1, "prefill");

    // Write then read
    do_write(BASE + 32'd8, 8'd0, SIZE_WORD, 32'hDEADBEEF, 4'hF, 1'b1, "wr_rd");
    do_read(BASE + 32'd8, 8'd0, SIZE_WORD, "wr_rd", rd);
    check("wr_rd literal", rd, 32'hDEADBEEF);

    // W three cycles ahead of AW
    s_wvalid = 1; s_wdata = 32'hCAFEF00D; s_wstrb = 4'hF; s_wlast = 1;
    step();
    s_wvalid = 0;
    check("w_first wready low", 32'(s_wready), 32'd0);
    check("w_first awready",    32'(s_awready), 32'd1);
    step();
    check("w_first no bvalid 1", 32'(s_bvalid), 32'd0);
    step();
    check("w_first no bvalid 2", 32'(s_bvalid), 32'd0);
    s_awvalid = 1; s_awaddr = BASE + 32'd12; s_awlen = 0; s_awsize = SIZE_WORD;
    step();
    s_awvalid = 0;
    check("w_first bvalid",  32'(s_bvalid),  32'd1);
    check("w_first bresp",   32'(s_bresp),   32'(RESP_OKAY));
    check("w_first awready", 32'(s_awready), 32'd0);
    s_bready = 1;
    step();
    s_bready = 0;
    check("w_first ready aw", 32'(s_awready), 32'd1);
    check("w_first ready w",  32'(s_wready),  32'd1);
    model[3] = 32'hCAFEF00D;
    do_read(BASE + 32'd12, 8'd0, SIZE_WORD, "w_first", rd);

    // Byte strobes
    do_write(BASE + 32'd20, 8'd0, SIZE_WORD, 32'h11223344, 4'hF, 1'b1, "strb base");
    do_write(BASE + 32'd20, 8'd0, SIZE_WORD, 32'hAABBCCDD, 4'b0101, 1'b1, "strb part");
    do_read(BASE + 32'd20, 8'd0, SIZE_WORD, "strb", rd);
    check("strb literal", rd, 32'h11BB33DD);

    // Error responses leave memory alone
    do_read(BASE + 32'd8, 8'd3, SIZE_WORD, "err len", rd);
    do_write(BASE + 32'(4 * DEPTH), 8'd0, SIZE_WORD, 32'h0BAD0BAD, 4'hF, 1'b1, "err range");
    do_read(BASE + 32'd10, 8'd0, SIZE_WORD, "err align", rd);
    do_write(BASE + 32'd8, 8'd0, SIZE_WORD, 32'h0BAD0BAD, 4'hF, 1'b0, "err wlast");
    do_write(BASE + 32'd8, 8'd0, 3'b001, 32'h0BAD0BAD, 4'hF, 1'b1, "err size");
    do_read(BASE + 32'd8, 8'd0, SIZE_WORD, "err unchanged", rd);
    check("err unchanged literal", rd, 32'hDEADBEEF);
    do_read(BASE - 32'd4, 8'd0, SIZE_WORD, "err below", rd);
    do_read(BASE + 32'(4 * DEPTH - 4), 8'd0, SIZE_WORD, "top word", rd);

    // Read samples a word on the same edge a write commits to it
    old = model[5];
    s_awvalid = 1; s_awaddr = BASE + 32'd20; s_awlen = 0; s_awsize = SIZE_WORD;
    s_wvalid = 1; s_wdata = 32'h5A5A5A5A; s_wstrb = 4'hF; s_wlast = 1;
    s_arvalid = 1; s_araddr = BASE + 32'd20; s_arlen = 0; s_arsize = SIZE_WORD;
    step();
    s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
    check("rbw bvalid", 32'(s_bvalid), 32'd1);
    check("rbw rvalid", 32'(s_rvalid), 32'd1);
    check("rbw old data", s_rdata, old);
    s_bready = 1; s_rready = 1;
    step();
    s_bready = 0; s_rready = 0;
    model[5] = 32'h5A5A5A5A;
    do_read(BASE + 32'd20, 8'd0, SIZE_WORD, "rbw new", rd);

    // Backpressure on B and R
    s_awvalid = 1; s_awaddr = BASE + 32'd24; s_awlen = 0; s_awsize = SIZE_WORD;
    s_wvalid = 1; s_wdata = 32'h01020304; s_wstrb = 4'hF; s_wlast = 1;
    s_arvalid = 1; s_araddr = BASE + 32'd28; s_arlen = 0; s_arsize = SIZE_WORD;
    step();
    s_wdata = 32'hFFFFFFFF; s_awaddr = BASE + 32'd24; s_araddr = BASE + 32'd24;
    hold_rdata = model[7];
    for (int i = 0; i < 5; i++) begin
      check("bp bvalid",  32'(s_bvalid),  32'd1);
      check("bp bresp",   32'(s_bresp),   32'(RESP_OKAY));
      check("bp rvalid",  32'(s_rvalid),  32'd1);
      check("bp rdata",   s_rdata,        hold_rdata);
      check("bp rresp",   32'(s_rresp),   32'(RESP_OKAY));
      check("bp awready", 32'(s_awready), 32'd0);
      check("bp wready",  32'(s_wready),  32'd0);
      check("bp arready", 32'(s_arready), 32'd0);
      step();
    end
    s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
    s_bready = 1; s_rready = 1;
    step();
    s_bready = 0; s_rready = 0;
    check("bp release bvalid",  32'(s_bvalid),  32'd0);
    check("bp release arready", 32'(s_arready), 32'd1);
    model[6] = 32'h01020304;
    do_read(BASE + 32'd24, 8'd0, SIZE_WORD, "bp stored", rd);

    // Reset while AW is held
    s_awvalid = 1; s_awaddr = BASE + 32'd32; s_awlen = 0; s_awsize = SIZE_WORD;
    step();
    s_awvalid = 0;
    check("midrst aw held", 32'(s_awready), 32'd0);
    resetn = 0;
    step();
    check("midrst bvalid",  32'(s_bvalid),  32'd0);
    check("midrst awready", 32'(s_awready), 32'd0);
    check("midrst wready",  32'(s_wready),  32'd0);
    check("midrst arready", 32'(s_arready), 32'd0);
    resetn = 1;
    #1;
    check("midrst after awready", 32'(s_awready), 32'd1);
    check("midrst after wready",  32'(s_wready),  32'd1);
    check("midrst after arready", 32'(s_arready), 32'd1);
    step();
    s_wvalid = 1; s_wdata = 32'h12345678; s_wstrb = 4'hF; s_wlast = 1;
    step();
    s_wvalid = 0;
    for (int i = 0; i < 3; i++) begin
      check("midrst no bvalid", 32'(s_bvalid), 32'd0);
      step();
    end
    // Retire the orphan W with an out-of-range AW
    s_awvalid = 1; s_awaddr = BASE + 32'(4 * DEPTH + 16);
    step();
    s_awvalid = 0;
    check("midrst orphan bvalid", 32'(s_bvalid), 32'd1);
    check("midrst orphan bresp",  32'(s_bresp),  32'(RESP_SLVERR));
    s_bready = 1;
    step();
    s_bready = 0;
    do_read(BASE + 32'd32, 8'd0, SIZE_WORD, "midrst unchanged", rd);

    // Random traffic
    for (int i = 0; i < 80; i++) begin
      kind = int'($urandom_range(0, 9));
      a   = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
      len = 8'd0;
      sz  = SIZE_WORD;
      case (kind)
        6: sz  = 3'($urandom_range(0, 1));
        7: a   = a + 32'($urandom_range(1, 3));
        8: a   = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 7));
        9: len = 8'($urandom_range(1, 255));
        default: ;
      endcase
      if ($urandom_range(0, 1) == 1)
        do_write(a, len, sz, $urandom, 4'($urandom), ($urandom_range(0, 9) != 0), "rand_wr");
      else
        do_read(a, len, sz, "rand_rd", rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
